register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
Parameters: none; width is fixed at 4 bits.
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 A  input  4  parallel data in; A[0] maps to q0 and A[3] maps to q3.
REQ-004 q0  output  1  stored bit 0.
REQ-005 q1  output  1  stored bit 1.
REQ-006 q2  output  1  stored bit 2.
REQ-007 q3  output  1  stored bit 3.
REQ-008 The block SHALL have one clock (clk) and one reset (rst_n), and no other control inputs.

Function
REQ-009 On every rising clk edge with rst_n=1, the block SHALL capture A[i] into qi for i=0..3 simultaneously.
REQ-010 Latency SHALL be one clock edge: a value on A before edge n SHALL appear on q0..q3 immediately after edge n.
REQ-011 Between rising edges, q0..q3 SHALL hold their values regardless of any change on A.
REQ-012 Falling clk edges SHALL have no effect.
REQ-013 There is no enable; the block SHALL load on every rising edge.
REQ-014 Each bit SHALL be stored in its own D flip-flop cell with clk, rst_n, d and q.
REQ-015 The four cells SHALL be instantiated in register, with each qi driven directly by a flip-flop output (no combinational logic on the output path).
REQ-016 The block SHALL contain no combinational path from A to q0..q3.
REQ-017 A X or Z value on A[i] at a capture edge SHALL propagate to qi only; other bits SHALL be unaffected.
REQ-018 The bits SHALL be independent; no bit SHALL depend on another bit's value.

Reset
REQ-019 When rst_n=0, q0..q3 SHALL go to 0 immediately, without waiting for clk.
REQ-020 While rst_n=0, rising clk edges SHALL be ignored and the outputs SHALL stay at 0.
REQ-021 Reset deassertion (0->1) SHALL NOT load A by itself; the first load SHALL occur on the next rising clk edge with rst_n=1.
REQ-022 If reset is asserted between capture edges, the outputs SHALL clear at once, and the data captured before the reset SHALL be lost.
REQ-023 When rst_n and a rising clk edge change at the same time, reset SHALL win and the outputs SHALL be 0.

Verification
Clock: period 10 ns, first rising edge at 5 ns.
REQ-024 Reset: rst_n=0 at t=0 with A=4'b1111 toggling clk -> q3..q0=0000 throughout; release rst_n -> next rising edge loads 1111.
REQ-025 Sequential load: with rst_n=1, apply A=0000 for the edge at 5 ns, 1010 for 15 ns, 1100 for 25 ns, 0011 for 35 ns -> after each edge q3..q0 equal 0000, 1010, 1100, 0011 respectively.
REQ-026 Hold: change A from 0011 to 1111 mid-cycle (clk low) -> q3..q0 stay 0011 until the next rising edge, then become 1111.
REQ-027 Async reset mid-cycle: with q3..q0=1010, pull rst_n low between edges -> q3..q0=0000 immediately, before any clk edge.
REQ-028 Bit mapping: load A=0001, then 0010, 0100, 1000 on successive edges -> exactly one of q0, q1, q2, q3 is high per cycle, in that order.
REQ-029 Falling edge: change A=0101 just before a falling edge -> q unchanged until the following rising edge.

Source files
------------

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module   : register
// Brief    : 4-bit parallel-load register built from four async-reset D cells.
// Revision : 1.0 - initial release
// ============================================================================

module register_dff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

module register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  output logic       q0,
  output logic       q1,
  output logic       q2,
  output logic       q3
);

  // Each output comes straight from its own cell; nothing sits between flop and port.
  register_dff u_bit0 (.clk(clk), .rst_n(rst_n), .d(A[0]), .q(q0));
  register_dff u_bit1 (.clk(clk), .rst_n(rst_n), .d(A[1]), .q(q1));
  register_dff u_bit2 (.clk(clk), .rst_n(rst_n), .d(A[2]), .q(q2));
  register_dff u_bit3 (.clk(clk), .rst_n(rst_n), .d(A[3]), .q(q3));

endmodule

`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// Self-checking bench for register: vector table plus directed reset/hold sequences.
module tb_register;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic       q0, q1, q2, q3;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [10];

  register dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .q0   (q0),
    .q1   (q1),
    .q2   (q2),
    .q3   (q3)
  );

  assign q = {q3, q2, q1, q0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] exp);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s: q3..q0 got %b expected %b at %0t", name, q, exp, $time);
    end
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'b0000};
    vecs[1] = '{4'b1010, 4'b1010};
    vecs[2] = '{4'b1100, 4'b1100};
    vecs[3] = '{4'b0011, 4'b0011};
    vecs[4] = '{4'b0001, 4'b0001};
    vecs[5] = '{4'b0010, 4'b0010};
    vecs[6] = '{4'b0100, 4'b0100};
    vecs[7] = '{4'b1000, 4'b1000};
    vecs[8] = '{4'b0110, 4'b0110};
    vecs[9] = '{4'b1111, 4'b1111};

    // Reset held with all-ones data: edges must be ignored
    rst_n = 1'b0;
    A     = 4'b1111;
    #1 check("reset_t0", 4'b0000);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold", 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_no_load", 4'b0000);
    @(posedge clk); #1;
    check("first_load", 4'b1111);

    // Table-driven loads, one vector per rising edge
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      A = vecs[i].a;
      #1 check("pre_edge_hold", vecs[(i == 0) ? 9 : i - 1].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Hold: change A while clk is low
    @(negedge clk);
    A = 4'b0011;
    @(posedge clk); #1;
    check("hold_setup", 4'b0011);
    @(negedge clk); #1;
    A = 4'b1111;
    #2 check("hold_mid_cycle", 4'b0011);
    @(posedge clk); #1;
    check("hold_after_edge", 4'b1111);

    // Falling edge: change A while clk is high, just before the falling edge
    #2 A = 4'b0101;
    @(negedge clk); #1;
    check("falling_edge_ignored", 4'b1111);
    @(posedge clk); #1;
    check("load_after_fall", 4'b0101);

    // Async reset mid-cycle
    @(negedge clk);
    A = 4'b1010;
    @(posedge clk); #1;
    check("async_setup", 4'b1010);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check("async_clear", 4'b0000);
    @(posedge clk); #1;
    check("async_edge_ignored", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("async_release", 4'b0000);
    @(posedge clk); #1;
    check("async_reload", 4'b1010);

    // Reset asserted coincident with a rising edge
    @(negedge clk);
    A = 4'b0111;
    @(posedge clk);
    rst_n = 1'b0;
    #1 check("reset_wins", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    A = 4'b1001;
    @(posedge clk); #1;
    check("post_race_load", 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
